pwm_multi_channel: RTL and testbench

Multi-channel PWM generator with one shared period counter, per-channel duty registers and glitch-free period-boundary updates. It supports edge-aligned and center-aligned modes and per-channel output polarity. It sits between the register/control logic and the LED/backlight/test-pattern outputs, and replaces single-channel, free-running PWM instances where several synchronised channels are needed.

---
 rtl/pwm_multi_channel_if.sv | 30 +++
 rtl/pwm_multi_channel.sv | 105 ++++++++++
 tb/tb_pwm_multi_channel.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_channel_if.sv
// Host-side bundle for pwm_multi_channel: run control, period/mode configuration,
// duty write port and the PWM outputs.
interface pwm_multi_channel_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                enable;
    logic                center_mode;
    logic [WIDTH-1:0]    period;
    logic [CHANNELS-1:0] polarity;
    // Duty write port: wr_en is a strobe with no back-pressure; every edge
    // with wr_en=1 and a legal wr_ch loads that channel's shadow duty.
    logic                wr_en;
    logic [CH_W-1:0]     wr_ch;
    logic [WIDTH-1:0]    wr_duty;
    logic [CHANNELS-1:0] pwm_out;
    logic                period_start;

    modport master (
        output enable, center_mode, period, polarity, wr_en, wr_ch, wr_duty,
        input  pwm_out, period_start
    );

    modport slave (
        input  enable, center_mode, period, polarity, wr_en, wr_ch, wr_duty,
        output pwm_out, period_start
    );
endinterface

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with a shared period counter, shadowed duties transferred at
// the period boundary, edge/center-aligned modes and live per-channel polarity.
module pwm_multi_channel #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pwm_multi_channel_if.slave   bus
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic                dir_q, dir_d;     // 0 = counting up, 1 = counting down
    logic [WIDTH-1:0]    per_a_q;
    logic                mode_a_q;
    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    duty_a_q [CHANNELS];
    logic [CHANNELS-1:0] raw;
    logic [CHANNELS-1:0] pwm_q;
    logic                ps_q;
    logic                reload;

    // reload marks the edge on which the counter returns to 0; while disabled
    // it is held high so configuration tracks the inputs every cycle.
    always_comb begin
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        reload = 1'b0;
        if (!bus.enable) begin
            cnt_d  = '0;
            reload = 1'b1;
        end else if (!mode_a_q) begin
            if (cnt_q >= per_a_q) begin
                cnt_d  = '0;
                reload = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (!dir_q) begin
            if (cnt_q < per_a_q) begin
                cnt_d = cnt_q + 1'b1;
            end else if (per_a_q <= WIDTH'(1)) begin
                cnt_d  = '0;
                reload = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
                dir_d = 1'b1;
            end
        end else begin
            if (cnt_q <= WIDTH'(1)) begin
                cnt_d  = '0;
                reload = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
        if (reload) begin
            dir_d = 1'b0;
        end
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            raw[i] = (cnt_q < duty_a_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            per_a_q  <= '0;
            mode_a_q <= 1'b0;
            pwm_q    <= '0;
            ps_q     <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
                duty_a_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            if (reload) begin
                per_a_q  <= bus.period;
                mode_a_q <= bus.center_mode;
            end
            // Active duty takes the pre-edge shadow, so a same-edge write waits a period.
            for (int i = 0; i < CHANNELS; i++) begin
                if (reload) begin
                    duty_a_q[i] <= shadow_q[i];
                end
                if (bus.wr_en && (bus.wr_ch == CH_W'(i))) begin
                    shadow_q[i] <= bus.wr_duty;
                end
            end
            pwm_q <= bus.enable ? (raw ^ bus.polarity) : bus.polarity;
            ps_q  <= bus.enable && (cnt_q == '0);
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.period_start = ps_q;
endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: directed scenarios plus random traffic checked
// against a position-in-period reference model.
module tb_pwm_multi_channel;
    localparam int W   = 8;
    localparam int NCH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_multi_channel_if #(.WIDTH(W), .CHANNELS(NCH)) bus ();
    pwm_multi_channel #(.WIDTH(W), .CHANNELS(NCH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Three-channel instance so that an out-of-range channel index exists.
    pwm_multi_channel_if #(.WIDTH(W), .CHANNELS(3)) bus3 ();
    pwm_multi_channel #(.WIDTH(W), .CHANNELS(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: position within the period, the period length, and the
    // configuration captured when the period began.
    int             m_pos;
    int             m_len;
    int             m_p;
    logic           m_mode;
    int             m_dsh [NCH];
    int             m_da  [NCH];
    logic [NCH-1:0] exp_pwm;
    logic           exp_ps;

    function automatic int cnt_at(int pos);
        if (m_mode && pos > m_p) return 2 * m_p - pos;
        return pos;
    endfunction

    function automatic int len_of(int p, logic c);
        if (!c) return p + 1;
        if (p == 0) return 1;
        return 2 * p;
    endfunction

    task automatic reload_model();
        for (int i = 0; i < NCH; i++) m_da[i] = m_dsh[i];
        m_p    = int'(bus.period);
        m_mode = bus.center_mode;
        m_len  = len_of(m_p, m_mode);
    endtask

    task automatic model_step();
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                m_dsh[i] = 0;
                m_da[i]  = 0;
            end
            m_p = 0; m_mode = 1'b0; m_len = 1; m_pos = 0;
            exp_pwm = '0; exp_ps = 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                exp_pwm[i] = bus.enable ? ((cnt_at(m_pos) < m_da[i]) ^ bus.polarity[i])
                                        : bus.polarity[i];
            end
            exp_ps = bus.enable && (m_pos == 0);
            if (!bus.enable) begin
                m_pos = 0;
                reload_model();
            end else begin
                m_pos++;
                if (m_pos >= m_len) begin
                    m_pos = 0;
                    reload_model();
                end
            end
            if (bus.wr_en) m_dsh[bus.wr_ch] = int'(bus.wr_duty);
        end
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_write(input logic en, input int ch, input int d);
        bus.wr_en   = en;
        bus.wr_ch   = 2'(ch);
        bus.wr_duty = W'(d);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.enable = 1'b1; bus.polarity = 4'b1111;
        set_write(1'b1, 1, 9);
        advance();
        advance();
        checks++;
        if (bus.pwm_out !== 4'b0000 || bus.period_start !== 1'b0) begin
            failures++;
            $display("FAIL reset: pwm_out=%b ps=%b expected 0000/0", bus.pwm_out, bus.period_start);
        end
        checks++;
        if (bus3.pwm_out !== 3'b000 || bus3.period_start !== 1'b0) begin
            failures++;
            $display("FAIL reset3: pwm_out=%b ps=%b expected 000/0", bus3.pwm_out, bus3.period_start);
        end
        rst_n = 1'b1;
        bus.enable = 1'b0; bus.polarity = '0;
        set_write(1'b0, 0, 0);
        advance();
    endtask

    task automatic test_illegal_write();
        int h0, h1, h2, np;
        h0 = 0; h1 = 0; h2 = 0; np = 0;
        bus3.enable = 1'b0; bus3.period = 8'd3; bus3.center_mode = 1'b0;
        bus3.wr_en = 1'b1; bus3.wr_ch = 2'd2; bus3.wr_duty = 8'd2;
        advance();
        bus3.wr_ch = 2'd3; bus3.wr_duty = 8'd4;
        advance();
        bus3.wr_en = 1'b0;
        advance();
        bus3.enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            advance();
            h0 += int'(bus3.pwm_out[0]);
            h1 += int'(bus3.pwm_out[1]);
            h2 += int'(bus3.pwm_out[2]);
            np += int'(bus3.period_start);
        end
        checks++;
        if (h0 != 0 || h1 != 0 || h2 != 4 || np != 2) begin
            failures++;
            $display("FAIL illegal_write: highs ch0=%0d ch1=%0d ch2=%0d starts=%0d expected 0 0 4 2",
                     h0, h1, h2, np);
        end
        bus3.enable = 1'b0;
    endtask

    task automatic test_edge_basic();
        int h0, h1, h2, h3, np, rise;
        h0 = 0; h1 = 0; h2 = 0; h3 = 0; np = 0; rise = 0;
        bus.enable = 1'b0; bus.center_mode = 1'b0; bus.period = 8'd9; bus.polarity = '0;
        set_write(1'b1, 0, 3);  advance();
        set_write(1'b1, 1, 0);  advance();
        set_write(1'b1, 2, 10); advance();
        set_write(1'b1, 3, 5);  advance();
        set_write(1'b0, 0, 0);  advance();
        bus.enable = 1'b1;
        for (int k = 0; k < 40; k++) begin
            advance();
            checks++;
            if (bus.pwm_out !== exp_pwm || bus.period_start !== exp_ps) begin
                failures++;
                $display("FAIL edge_basic cyc %0d: pwm_out=%b ps=%b expected %b/%b",
                         k, bus.pwm_out, bus.period_start, exp_pwm, exp_ps);
            end
            h0 += int'(bus.pwm_out[0]); h1 += int'(bus.pwm_out[1]);
            h2 += int'(bus.pwm_out[2]); h3 += int'(bus.pwm_out[3]);
            np += int'(bus.period_start);
            rise += int'(bus.period_start && bus.pwm_out[0]);
        end
        checks++;
        if (h0 != 12 || h1 != 0 || h2 != 40 || h3 != 20 || np != 4 || rise != 4) begin
            failures++;
            $display("FAIL edge_counts: h=%0d,%0d,%0d,%0d starts=%0d aligned=%0d expected 12,0,40,20 4 4",
                     h0, h1, h2, h3, np, rise);
        end
    endtask

    task automatic test_shadow_update();
        int hi;
        for (int k = 0; k < 20 && m_pos != 5; k++) advance();
        set_write(1'b1, 0, 7);
        advance();
        set_write(1'b0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            advance();
            checks++;
            if (bus.pwm_out !== exp_pwm || bus.period_start !== exp_ps) begin
                failures++;
                $display("FAIL shadow_wait cyc %0d: pwm_out=%b ps=%b expected %b/%b",
                         k, bus.pwm_out, bus.period_start, exp_pwm, exp_ps);
            end
            if (bus.period_start) break;
        end
        hi = int'(bus.pwm_out[0]);
        for (int k = 0; k < 9; k++) begin
            advance();
            hi += int'(bus.pwm_out[0]);
        end
        checks++;
        if (hi !== 7) begin
            failures++;
            $display("FAIL shadow_next_period: ch0 high=%0d expected 7", hi);
        end
        for (int k = 0; k < 20 && m_pos != 9; k++) advance();
        set_write(1'b1, 0, 2);
        advance();
        set_write(1'b0, 0, 0);
        for (int p = 0; p < 2; p++) begin
            hi = 0;
            for (int k = 0; k < 10; k++) begin
                advance();
                checks++;
                if (bus.pwm_out !== exp_pwm || bus.period_start !== exp_ps) begin
                    failures++;
                    $display("FAIL shadow_boundary cyc %0d: pwm_out=%b ps=%b expected %b/%b",
                             k, bus.pwm_out, bus.period_start, exp_pwm, exp_ps);
                end
                hi += int'(bus.pwm_out[0]);
            end
            checks++;
            if (hi != ((p == 0) ? 7 : 2)) begin
                failures++;
                $display("FAIL shadow_boundary_period%0d: ch0 high=%0d expected %0d",
                         p, hi, (p == 0) ? 7 : 2);
            end
        end
    endtask

    task automatic test_center();
        logic [7:0] pat;
        int h1, h3, np;
        pat = 8'b1000_0011;
        h1 = 0; h3 = 0; np = 0;
        bus.enable = 1'b0; bus.center_mode = 1'b1; bus.period = 8'd4;
        set_write(1'b1, 0, 2); advance();
        set_write(1'b1, 1, 5); advance();
        set_write(1'b1, 2, 0); advance();
        set_write(1'b1, 3, 4); advance();
        set_write(1'b0, 0, 0); advance();
        bus.enable = 1'b1;
        for (int k = 0; k < 16; k++) begin
            advance();
            checks++;
            if (bus.pwm_out[0] !== pat[k % 8] || bus.pwm_out !== exp_pwm
                || bus.period_start !== exp_ps) begin
                failures++;
                $display("FAIL center cyc %0d: pwm_out=%b ps=%b expected %b/%b (ch0 %b)",
                         k, bus.pwm_out, bus.period_start, exp_pwm, exp_ps, pat[k % 8]);
            end
            h1 += int'(bus.pwm_out[1]);
            h3 += int'(bus.pwm_out[3]);
            np += int'(bus.period_start);
        end
        checks++;
        if (h1 != 16 || h3 != 14 || np != 2) begin
            failures++;
            $display("FAIL center_counts: ch1=%0d ch3=%0d starts=%0d expected 16 14 2", h1, h3, np);
        end
    endtask

    task automatic test_mode_change();
        int n;
        for (int k = 0; k < 20 && m_pos != 3; k++) advance();
        bus.center_mode = 1'b0; bus.period = 8'd6;
        for (int p = 0; p < 3; p++) begin
            n = 0;
            for (int k = 0; k < 20; k++) begin
                advance();
                n++;
                checks++;
                if (bus.pwm_out !== exp_pwm || bus.period_start !== exp_ps) begin
                    failures++;
                    $display("FAIL mode_change cyc %0d: pwm_out=%b ps=%b expected %b/%b",
                             k, bus.pwm_out, bus.period_start, exp_pwm, exp_ps);
                end
                if (bus.period_start) break;
            end
            checks++;
            if (n != ((p == 0) ? 6 : 7)) begin
                failures++;
                $display("FAIL mode_change_len%0d: cycles=%0d expected %0d", p, n, (p == 0) ? 6 : 7);
            end
        end
    endtask

    task automatic test_polarity_enable();
        bus.enable = 1'b0; bus.polarity = 4'b1010;
        for (int k = 0; k < 2; k++) begin
            advance();
            checks++;
            if (bus.pwm_out !== 4'b1010 || bus.period_start !== 1'b0) begin
                failures++;
                $display("FAIL idle_level: pwm_out=%b ps=%b expected 1010/0", bus.pwm_out, bus.period_start);
            end
        end
        bus.enable = 1'b1;
        advance();
        checks++;
        if (bus.period_start !== 1'b1 || bus.pwm_out !== exp_pwm) begin
            failures++;
            $display("FAIL enable_first: pwm_out=%b ps=%b expected %b/1", bus.pwm_out, bus.period_start, exp_pwm);
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 2) bus.polarity = 4'b0101;
            advance();
            checks++;
            if (bus.pwm_out !== exp_pwm || bus.period_start !== exp_ps) begin
                failures++;
                $display("FAIL polarity_live cyc %0d: pwm_out=%b ps=%b expected %b/%b",
                         k, bus.pwm_out, bus.period_start, exp_pwm, exp_ps);
            end
        end
        bus.enable = 1'b0;
        advance();
        checks++;
        if (bus.pwm_out !== 4'b0101 || bus.period_start !== 1'b0) begin
            failures++;
            $display("FAIL disable_mid: pwm_out=%b ps=%b expected 0101/0", bus.pwm_out, bus.period_start);
        end
    endtask

    task automatic test_random();
        bus.enable = 1'b1; bus.polarity = '0;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 39) == 0) bus.period = W'($urandom_range(0, 12));
            if ($urandom_range(0, 59) == 0) bus.center_mode = ~bus.center_mode;
            if ($urandom_range(0, 49) == 0) bus.polarity = NCH'($urandom);
            if ($urandom_range(0, 59) == 0) bus.enable = ~bus.enable;
            if ($urandom_range(0, 5) == 0) set_write(1'b1, int'($urandom_range(0, NCH - 1)),
                                                     int'($urandom_range(0, 14)));
            else set_write(1'b0, 0, 0);
            advance();
            checks++;
            if (bus.pwm_out !== exp_pwm || bus.period_start !== exp_ps) begin
                failures++;
                $display("FAIL random cyc %0d: pwm_out=%b ps=%b expected %b/%b",
                         k, bus.pwm_out, bus.period_start, exp_pwm, exp_ps);
            end
        end
        set_write(1'b0, 0, 0);
    endtask

    task automatic test_reset_mid();
        bus.enable = 1'b1; bus.polarity = '0; bus.center_mode = 1'b0; bus.period = 8'd5;
        for (int i = 0; i < NCH; i++) begin
            set_write(1'b1, i, 3);
            advance();
        end
        set_write(1'b0, 0, 0);
        for (int k = 0; k < 9; k++) advance();
        rst_n = 1'b0;
        advance();
        checks++;
        if (bus.pwm_out !== 4'b0000 || bus.period_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: pwm_out=%b ps=%b expected 0000/0", bus.pwm_out, bus.period_start);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 14; k++) begin
            advance();
            checks++;
            if (bus.pwm_out !== 4'b0000 || bus.period_start !== exp_ps) begin
                failures++;
                $display("FAIL after_reset cyc %0d: pwm_out=%b ps=%b expected 0000/%b",
                         k, bus.pwm_out, bus.period_start, exp_ps);
            end
        end
    endtask

    initial begin
        bus.enable = 1'b0; bus.center_mode = 1'b0; bus.period = '0; bus.polarity = '0;
        bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_duty = '0;
        bus3.enable = 1'b0; bus3.center_mode = 1'b0; bus3.period = '0; bus3.polarity = '0;
        bus3.wr_en = 1'b0; bus3.wr_ch = '0; bus3.wr_duty = '0;
        test_reset();
        test_illegal_write();
        test_edge_basic();
        test_shadow_update();
        test_center();
        test_mode_change();
        test_polarity_enable();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
